// File: rtl/usart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usart_pkg
//  Purpose  : Shared status codes, FSM encoding and command record layout
//             for the USART command scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package usart_pkg;

  localparam int CMD_W = 32;  // {addr[1:0], sel[5:0], data[23:0]}

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_OVF     = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  function automatic logic [3:0] addr_onehot(input logic [1:0] a);
    return 4'b0001 << a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usart_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : usart_cmd_fifo
//  Purpose  : Synchronous FIFO with registered count; head is shown
//             combinationally on o_dout.
//  Revision : 1.0 - initial release
// ============================================================================
module usart_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // Full is judged on the registered count, so a push at full is refused
  // even when a pop happens in the same cycle.
  assign w_wr = i_push && !o_full;
  assign w_rd = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/usart_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : usart_cmd_sched
//  Purpose  : Buffers decoded UART commands, dispatches them one at a time to
//             four targets over req/ack with timeout, and reports a status.
//  Revision : 1.0 - initial release
// ============================================================================
module usart_cmd_sched
  import usart_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter logic [15:0] TIMEOUT = 16'd5000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_vld,
  input  logic [1:0]  cmd_addr,
  input  logic [5:0]  cmd_sel,
  input  logic [23:0] cmd_data,
  output logic        cmd_full,
  output logic [3:0]  dst_req,
  output logic [5:0]  dst_sel,
  output logic [23:0] dst_data,
  input  logic [3:0]  dst_ack,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [1:0]  rsp_addr,
  output logic [1:0]  rsp_status,
  output logic [7:0]  ovf_cnt,
  output logic        busy
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_timer;
  logic                  r_ovf_pend;
  logic [7:0]            r_ovf_cnt;
  logic [1:0]            r_addr;
  logic [5:0]            r_sel;
  logic [23:0]           r_data;
  logic [1:0]            r_rsp_addr;
  logic [1:0]            r_rsp_status;

  logic [CMD_W-1:0]      w_head;
  logic [$clog2(DEPTH):0] w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_ack;
  logic                  w_timeout;
  logic                  w_load_ovf;
  logic                  w_load_done;
  logic [1:0]            w_done_status;

  assign w_push    = cmd_vld && !w_full;
  assign w_drop    = cmd_vld && w_full;
  assign w_ack     = dst_ack[r_addr];
  assign w_timeout = (r_timer == TIMEOUT - 16'd1);

  usart_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst),
    .i_push  (w_push),
    .i_din   ({cmd_addr, cmd_sel, cmd_data}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_load_ovf    = 1'b0;
    w_load_done   = 1'b0;
    w_done_status = ST_OK;
    case (r_state)
      S_IDLE: begin
        // A pending overflow report goes out before any queued command.
        if (r_ovf_pend) begin
          w_load_ovf  = 1'b1;
          w_state_nxt = S_RESP;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_ack) begin
          w_load_done = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_timeout) begin
          w_load_done   = 1'b1;
          w_done_status = ST_TIMEOUT;
          w_state_nxt   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_rdy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_ovf_pend   <= 1'b0;
      r_ovf_cnt    <= '0;
      r_addr       <= '0;
      r_sel        <= '0;
      r_data       <= '0;
      r_rsp_addr   <= '0;
      r_rsp_status <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_ISSUE && w_state_nxt == S_ISSUE) r_timer <= r_timer + 16'd1;
      else                                              r_timer <= '0;

      // A drop in the same cycle as the report load keeps a report pending.
      if (w_drop)          r_ovf_pend <= 1'b1;
      else if (w_load_ovf) r_ovf_pend <= 1'b0;

      if (w_drop && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;

      if (w_pop) begin
        r_addr <= w_head[31:30];
        r_sel  <= w_head[29:24];
        r_data <= w_head[23:0];
      end

      if (w_load_ovf) begin
        r_rsp_addr   <= 2'b00;
        r_rsp_status <= ST_OVF;
      end else if (w_load_done) begin
        r_rsp_addr   <= r_addr;
        r_rsp_status <= w_done_status;
      end
    end
  end

  assign dst_req    = (r_state == S_ISSUE) ? addr_onehot(r_addr) : 4'b0000;
  assign dst_sel    = r_sel;
  assign dst_data   = r_data;
  assign rsp_vld    = (r_state == S_RESP);
  assign rsp_addr   = r_rsp_addr;
  assign rsp_status = r_rsp_status;
  assign ovf_cnt    = r_ovf_cnt;
  assign cmd_full   = w_full;
  assign busy       = (r_state != S_IDLE) || (w_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_usart_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usart_cmd_sched
//  Purpose  : Directed self-checking bench for usart_cmd_sched
//             (DEPTH = 4, TIMEOUT = 8). Inputs change and outputs are
//             sampled on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usart_cmd_sched;

  logic        sys_clk  = 1'b0;
  logic        sys_rst  = 1'b0;
  logic        cmd_vld  = 1'b0;
  logic [1:0]  cmd_addr = '0;
  logic [5:0]  cmd_sel  = '0;
  logic [23:0] cmd_data = '0;
  logic        cmd_full;
  logic [3:0]  dst_req;
  logic [5:0]  dst_sel;
  logic [23:0] dst_data;
  logic [3:0]  dst_ack  = '0;
  logic        rsp_vld;
  logic        rsp_rdy  = 1'b0;
  logic [1:0]  rsp_addr;
  logic [1:0]  rsp_status;
  logic [7:0]  ovf_cnt;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  usart_cmd_sched #(
    .DEPTH   (4),
    .TIMEOUT (16'd8)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cmd_vld    (cmd_vld),
    .cmd_addr   (cmd_addr),
    .cmd_sel    (cmd_sel),
    .cmd_data   (cmd_data),
    .cmd_full   (cmd_full),
    .dst_req    (dst_req),
    .dst_sel    (dst_sel),
    .dst_data   (dst_data),
    .dst_ack    (dst_ack),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_addr   (rsp_addr),
    .rsp_status (rsp_status),
    .ovf_cnt    (ovf_cnt),
    .busy       (busy)
  );

  // Called on a falling edge; returns on the next falling edge.
  task automatic push(input logic [1:0] a, input logic [5:0] s, input logic [23:0] d);
    cmd_vld = 1'b1; cmd_addr = a; cmd_sel = s; cmd_data = d;
    @(negedge sys_clk);
    cmd_vld = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int i = 0;
    while (dst_req == 4'b0 && i < 40) begin @(negedge sys_clk); i++; end
    if (dst_req == 4'b0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: dst_req stayed %b, required nonzero within 40 cycles", nm, dst_req);
    end
  endtask

  task automatic wait_rsp(input string nm);
    int i = 0;
    while (rsp_vld !== 1'b1 && i < 40) begin @(negedge sys_clk); i++; end
    if (rsp_vld !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL %s: rsp_vld stayed %b, required 1 within 40 cycles", nm, rsp_vld);
    end
  endtask

  task automatic expect_rsp(input logic [1:0] a, input logic [1:0] st, input string nm);
    wait_rsp(nm);
    n_cmp++;
    if (rsp_addr !== a || rsp_status !== st) begin
      n_err++;
      $display("FAIL %s rsp: addr/status got %h/%b, required %h/%b", nm, rsp_addr, rsp_status, a, st);
    end
    rsp_rdy = 1'b1;
    @(negedge sys_clk);
    rsp_rdy = 1'b0;
    n_cmp++;
    if (rsp_vld !== 1'b0) begin
      n_err++;
      $display("FAIL %s rsp_drop: rsp_vld got %b, required 0", nm, rsp_vld);
    end
  endtask

  task automatic serve(input logic [1:0] a, input logic [23:0] d, input string nm);
    logic [3:0] oh;
    oh = 4'b0001 << a;
    wait_req(nm);
    n_cmp++;
    if (dst_req !== oh || dst_data !== d) begin
      n_err++;
      $display("FAIL %s req: req/data got %b/%h, required %b/%h", nm, dst_req, dst_data, oh, d);
    end
    dst_ack = oh;
    @(negedge sys_clk);
    dst_ack = 4'b0;
    expect_rsp(a, 2'b00, nm);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge sys_clk);
    n_cmp++;
    if ({cmd_full, dst_req, dst_sel, dst_data, rsp_vld, rsp_addr, rsp_status, ovf_cnt, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: full=%b req=%b sel=%h data=%h vld=%b addr=%h st=%b ovf=%0d busy=%b, required all 0",
               cmd_full, dst_req, dst_sel, dst_data, rsp_vld, rsp_addr, rsp_status, ovf_cnt, busy);
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_single;
    push(2'd2, 6'h15, 24'hABCDEF);
    n_cmp++;
    if (dst_req !== 4'b0000) begin
      n_err++; $display("FAIL single_lat1: dst_req got %b, required 0000", dst_req);
    end
    @(negedge sys_clk);
    n_cmp++;
    if (dst_req !== 4'b0100 || dst_sel !== 6'h15 || dst_data !== 24'hABCDEF) begin
      n_err++;
      $display("FAIL single_lat2: req/sel/data got %b/%h/%h, required 0100/15/abcdef", dst_req, dst_sel, dst_data);
    end
    repeat (3) @(negedge sys_clk);
    dst_ack = 4'b0100;
    @(negedge sys_clk);
    dst_ack = 4'b0;
    n_cmp++;
    if (dst_req !== 4'b0000 || rsp_vld !== 1'b1) begin
      n_err++; $display("FAIL single_ack: req/vld got %b/%b, required 0000/1", dst_req, rsp_vld);
    end
    expect_rsp(2'd2, 2'b00, "single");
  endtask

  task automatic test_timeout;
    int hi = 0;
    push(2'd1, 6'h01, 24'h000111);
    for (int i = 0; i < 30 && rsp_vld !== 1'b1; i++) begin
      if (dst_req === 4'b0010) hi++;
      @(negedge sys_clk);
    end
    n_cmp++;
    if (hi != 8) begin
      n_err++; $display("FAIL timeout_len: dst_req[1] high %0d cycles, required 8", hi);
    end
    expect_rsp(2'd1, 2'b01, "timeout");
  endtask

  // Ack lands on the very cycle the timer reaches TIMEOUT-1; ack must win.
  task automatic test_ack_at_timeout;
    push(2'd2, 6'h02, 24'h000222);
    wait_req("ack_edge");
    repeat (7) @(negedge sys_clk);
    n_cmp++;
    if (dst_req !== 4'b0100) begin
      n_err++; $display("FAIL ack_edge_req: dst_req got %b, required 0100", dst_req);
    end
    dst_ack = 4'b0100;
    @(negedge sys_clk);
    dst_ack = 4'b0;
    expect_rsp(2'd2, 2'b00, "ack_edge");
  endtask

  task automatic test_overflow;
    logic [5:0] full_exp;
    full_exp = 6'b110000;
    for (int i = 0; i < 6; i++) begin
      push(2'd0, 6'h20 + 6'(i), 24'hC00000 + 24'(i));
      n_cmp++;
      if (cmd_full !== full_exp[i]) begin
        n_err++; $display("FAIL ovf_full[%0d]: cmd_full got %b, required %b", i, cmd_full, full_exp[i]);
      end
    end
    n_cmp++;
    if (ovf_cnt !== 8'd1 || dst_req !== 4'b0001 || dst_data !== 24'hC00000) begin
      n_err++;
      $display("FAIL ovf_state: ovf/req/data got %0d/%b/%h, required 1/0001/c00000", ovf_cnt, dst_req, dst_data);
    end
    dst_ack = 4'b0001;
    @(negedge sys_clk);
    dst_ack = 4'b0;
    expect_rsp(2'd0, 2'b00, "ovf_first");
    n_cmp++;
    if (dst_req !== 4'b0000) begin
      n_err++; $display("FAIL ovf_order: dst_req got %b before overflow report, required 0000", dst_req);
    end
    expect_rsp(2'd0, 2'b10, "ovf_report");
    for (int i = 1; i < 5; i++) serve(2'd0, 24'hC00000 + 24'(i), "ovf_drain");
    n_cmp++;
    if (ovf_cnt !== 8'd1 || busy !== 1'b0) begin
      n_err++; $display("FAIL ovf_end: ovf/busy got %0d/%b, required 1/0", ovf_cnt, busy);
    end
  endtask

  task automatic test_wrong_ack;
    push(2'd0, 6'h2A, 24'h5A5A5A);
    wait_req("wrong_ack");
    dst_ack = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk);
      dst_ack = 4'b0;
      n_cmp++;
      if (dst_req !== 4'b0001 || rsp_vld !== 1'b0) begin
        n_err++; $display("FAIL wrong_ack[%0d]: req/vld got %b/%b, required 0001/0", i, dst_req, rsp_vld);
      end
    end
    dst_ack = 4'b0001;
    @(negedge sys_clk);
    dst_ack = 4'b0;
    expect_rsp(2'd0, 2'b00, "wrong_ack");
  endtask

  task automatic test_rsp_stall;
    int bad = 0;
    push(2'd3, 6'h33, 24'h333333);
    push(2'd2, 6'h22, 24'h222222);
    wait_req("stall");
    dst_ack = 4'b1000;
    @(negedge sys_clk);
    dst_ack = 4'b0;
    wait_rsp("stall");
    repeat (20) begin
      if (rsp_vld !== 1'b1 || rsp_addr !== 2'd3 || rsp_status !== 2'b00 || dst_req !== 4'b0 || busy !== 1'b1) bad++;
      @(negedge sys_clk);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL rsp_stall: %0d unstable cycles, required 0", bad);
    end
    expect_rsp(2'd3, 2'b00, "stall");
    serve(2'd2, 24'h222222, "stall_next");
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    push(2'd1, 6'h11, 24'h111111);
    push(2'd0, 6'h10, 24'h101010);
    push(2'd3, 6'h13, 24'h131313);
    wait_req("rst_mid");
    #2 sys_rst = 1'b0;
    #1;
    n_cmp++;
    if (dst_req !== 4'b0 || cmd_full !== 1'b0 || busy !== 1'b0 || ovf_cnt !== 8'd0 || rsp_vld !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid: req/full/busy/ovf/vld got %b/%b/%b/%0d/%b, required 0000/0/0/0/0",
               dst_req, cmd_full, busy, ovf_cnt, rsp_vld);
    end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (15) begin
      @(negedge sys_clk);
      if (rsp_vld !== 1'b0 || dst_req !== 4'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL rst_after: %0d cycles with activity after release, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_ack_at_timeout();
    test_overflow();
    test_wrong_ack();
    test_rsp_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
